// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage downstream of the execute-stage ALU. It accepts one RV32I load
// or store at a time, decodes width and alignment, and drives a single-ported
// data memory that may insert wait states. The result goes to writeback as a
// one-cycle wb_valid pulse, or as a one-cycle err pulse with a cause code.
//
// Optional feature: define LSU_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES cycles without mem_ack (err_code 11). Without the macro the
// LSU waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             execute-stage request (valid/ready handshake)
//   mem_*             data memory request, word address, byte enables, data
//   wb_valid/rd/data  writeback pulse, destination and extended load data
//   err, err_code     rejection pulse: 01 misaligned, 10 illegal, 11 timeout
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_store_q, is_store_d;
    // 00 means success; any other value is the cause reported in DONE
    logic [1:0]  err_code_q, err_code_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [1:0]  off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rdata_shift;
    logic [15:0] rdata_half;
    logic [31:0] load_data;
    logic        timeout;

    // Request decode, evaluated on the incoming (not yet latched) request
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (req_is_store) begin
            req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        end
        unique case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    // Byte enables and replicated store data for the latched access
    assign off = addr_q[1:0];

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        unique case (funct3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << off;
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    // Lane select and extension of the captured read word
    assign rdata_shift = rdata_q >> {off, 3'b000};
    assign rdata_half  = off[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_data = rdata_q;
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_half[15]}}, rdata_half};
            3'b100:  load_data = {24'h0, rdata_shift[7:0]};
            3'b101:  load_data = {16'h0, rdata_half};
            default: load_data = rdata_q;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts ACCESS cycles without mem_ack; held at zero outside ACCESS so it
    // is clear on every entry. Saturates rather than wrapping.
    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (state_q != StAccess) begin
            cnt_d = '0;
        end else if (!mem_ack) begin
            timeout = ({{(32 - CntW){1'b0}}, cnt_q} + 32'd1) >= TIMEOUT_CYCLES;
            if (cnt_q != {CntW{1'b1}}) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        is_store_d = is_store_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    rd_d       = req_rd;
                    is_store_d = req_is_store;
                    if (req_illegal) begin
                        err_code_d = 2'b10;
                        state_d    = StDone;
                    end else if (req_misaligned) begin
                        err_code_d = 2'b01;
                        state_d    = StDone;
                    end else begin
                        err_code_d = 2'b00;
                        state_d    = StAccess;
                    end
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = StDone;
                end else if (timeout) begin
                    err_code_d = 2'b11;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            is_store_q <= is_store_d;
            err_code_q <= err_code_d;
        end
    end

    // Outputs are decoded from state so they are all zero outside their phase
    always_comb begin
        req_ready = (state_q == StIdle);
        mem_req   = (state_q == StAccess);
        mem_we    = mem_req & is_store_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = mem_req ? lane_be : 4'b0000;
        mem_wdata = mem_we ? lane_wdata : 32'h0;
        wb_valid  = (state_q == StDone) && (err_code_q == 2'b00);
        err       = (state_q == StDone) && (err_code_q != 2'b00);
        err_code  = err ? err_code_q : 2'b00;
        wb_rd     = (wb_valid && !is_store_q) ? rd_q : 5'd0;
        wb_data   = (wb_valid && !is_store_q) ? load_data : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_is_store(req_is_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err         (err),
        .err_code    (err_code)
    );

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  e_code;
        logic [3:0]  e_be;
        logic [31:0] e_mwdata;
        logic [31:0] e_data;
    } txn_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] rdata, input int waits,
                                input logic [1:0] e_code, input logic [3:0] e_be,
                                input logic [31:0] e_mwdata, input logic [31:0] e_data);
        txn_t t;
        t.is_store = st;   t.f3 = f3;       t.addr = addr;       t.wdata = wdata;
        t.rd = rd;         t.rdata = rdata; t.waits = waits;     t.e_code = e_code;
        t.e_be = e_be;     t.e_mwdata = e_mwdata;                t.e_data = e_data;
        return t;
    endfunction

    // Reference: access size in bytes, lane offset, masks and sign bits by arithmetic
    function automatic txn_t model(input txn_t t);
        txn_t        r = t;
        int unsigned size = 1 << t.f3[1:0];
        int unsigned off  = t.addr % 4;
        logic        illegal;
        logic [63:0] v, mask;
        if (t.is_store) illegal = !(t.f3 inside {3'd0, 3'd1, 3'd2});
        else            illegal = t.f3 inside {3'd3, 3'd6, 3'd7};
        if (illegal)                   r.e_code = 2'b10;
        else if ((t.addr % size) != 0) r.e_code = 2'b01;
        else                           r.e_code = 2'b00;
        r.e_be = 4'(((64'd1 << size) - 1) << off);
        r.e_mwdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r.e_mwdata[8*i +: 8] = 8'(t.wdata >> (8 * (i % size)));
        end
        mask = (64'd1 << (8 * size)) - 1;
        v = (64'(t.rdata) >> (8 * off)) & mask;
        if (!t.f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        r.e_data = t.is_store ? 32'h0 : v[31:0];
        return r;
    endfunction

    // Issues one request, answers mem_req after t.waits wait cycles, checks everything
    task automatic run_txn(input txn_t t, input string tag);
        int          k;
        int          done_k = -1;
        int          nreq = 0;
        int          busy = 0;
        int          wl = t.waits;
        logic        got_wb = 1'b0, got_err = 1'b0, stable = 1'b1, we0 = 1'b0;
        logic [1:0]  got_code = 2'b00;
        logic [4:0]  got_rd = 5'd0;
        logic [31:0] got_data = 32'h0, a0 = 32'h0, w0 = 32'h0;
        logic [3:0]  be0 = 4'h0;
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_is_store = t.is_store;
        req_funct3   = t.f3;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        req_rd       = t.rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (k = 0; k < 64; k++) begin
            if (!req_ready) busy++;
            if (wb_valid || err) begin
                done_k   = k;
                got_wb   = wb_valid;
                got_err  = err;
                got_code = err_code;
                got_rd   = wb_rd;
                got_data = wb_data;
                break;
            end
            if (mem_req) begin
                if (nreq == 0) begin
                    a0 = mem_addr; be0 = mem_be; we0 = mem_we; w0 = mem_wdata;
                end else if (mem_addr !== a0 || mem_be !== be0 || mem_we !== we0 ||
                             (we0 && mem_wdata !== w0)) begin
                    stable = 1'b0;
                end
                nreq++;
                if (wl == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = t.rdata;
                end else begin
                    wl--;
                    mem_rdata = $urandom;
                end
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
            @(negedge clk);
        end
        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL %s.no_completion got=none exp=wb_valid_or_err", tag);
            return;
        end
        check({tag, ".done_cycle"}, 32'(done_k), (t.e_code != 0) ? 32'd0 : 32'(t.waits + 1));
        check({tag, ".busy"}, 32'(busy), (t.e_code != 0) ? 32'd1 : 32'(t.waits + 2));
        check({tag, ".wb_valid"}, 32'(got_wb), 32'(t.e_code == 2'b00));
        check({tag, ".err"}, 32'(got_err), 32'(t.e_code != 2'b00));
        check({tag, ".err_code"}, 32'(got_code), 32'(t.e_code));
        if (t.e_code != 2'b00) begin
            check({tag, ".nreq"}, 32'(nreq), 32'd0);
        end else begin
            check({tag, ".nreq"}, 32'(nreq), 32'(t.waits + 1));
            check({tag, ".mem_addr"}, a0, {t.addr[31:2], 2'b00});
            check({tag, ".mem_be"}, 32'(be0), 32'(t.e_be));
            check({tag, ".mem_we"}, 32'(we0), 32'(t.is_store));
            check({tag, ".stable"}, 32'(stable), 32'd1);
            if (t.is_store) check({tag, ".mem_wdata"}, w0, t.e_mwdata);
            check({tag, ".wb_rd"}, 32'(got_rd), t.is_store ? 32'd0 : 32'(t.rd));
            check({tag, ".wb_data"}, got_data, t.e_data);
        end
    endtask

    txn_t vec[12];
    txn_t rt;

    initial begin
        // Directed table; expected fields worked out by hand
        vec[0]  = mk(0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80FF_1234, 2,
                     2'b00, 4'b1000, 32'h0, 32'hFFFF_FF80);
        vec[1]  = mk(1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 32'h0, 0,
                     2'b00, 4'b1100, 32'hABCD_ABCD, 32'h0);
        vec[2]  = mk(0, 3'b010, 32'h006, 32'h0, 5'd3, 32'h0, 0,
                     2'b01, 4'b0000, 32'h0, 32'h0);
        vec[3]  = mk(0, 3'b101, 32'h006, 32'h0, 5'd4, 32'hBEEF_0000, 1,
                     2'b00, 4'b1100, 32'h0, 32'h0000_BEEF);
        vec[4]  = mk(0, 3'b110, 32'h000, 32'h0, 5'd6, 32'h0, 0,
                     2'b10, 4'b0000, 32'h0, 32'h0);
        vec[5]  = mk(1, 3'b000, 32'h001, 32'h0000_00A5, 5'd1, 32'h0, 1,
                     2'b00, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        vec[6]  = mk(1, 3'b010, 32'h003, 32'h1, 5'd1, 32'h0, 0,
                     2'b01, 4'b0000, 32'h0, 32'h0);
        vec[7]  = mk(1, 3'b100, 32'h000, 32'h1, 5'd1, 32'h0, 0,
                     2'b10, 4'b0000, 32'h0, 32'h0);
        vec[8]  = mk(0, 3'b001, 32'h000, 32'h0, 5'd7, 32'h0000_8001, 0,
                     2'b00, 4'b0011, 32'h0, 32'hFFFF_8001);
        vec[9]  = mk(0, 3'b100, 32'h002, 32'h0, 5'd8, 32'h00AB_0000, 3,
                     2'b00, 4'b0100, 32'h0, 32'h0000_00AB);
        vec[10] = mk(0, 3'b010, 32'h008, 32'h0, 5'd0, 32'hDEAD_BEEF, 0,
                     2'b00, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        vec[11] = mk(1, 3'b010, 32'h00C, 32'hCAFE_F00D, 5'd2, 32'h0, 2,
                     2'b00, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Reset state
        #12;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.outs", {mem_we, mem_be, err, err_code, wb_valid, wb_rd} , 32'd0);
        check("rst.mem_addr", mem_addr | mem_wdata | wb_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(vec[i], $sformatf("vec%0d", i));

        // Spurious ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("spurious.wb_err", {30'h0, wb_valid, err}, 32'h0);
        end

        // Reset during ACCESS: drop request at once, ignore late ack, then recover
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstacc.in_access", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstacc.mem_req_drop", 32'(mem_req), 32'd0);
        check("rstacc.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstacc.late_ack", {29'h0, wb_valid, err, mem_req}, 32'h0);
        end
        run_txn(mk(0, 3'b010, 32'h14, 32'h0, 5'd11, 32'h0BAD_F00D, 1,
                   2'b00, 4'b1111, 32'h0, 32'h0BAD_F00D), "rstacc.next_lw");

        // Randomized accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            rt.is_store = 1'($urandom);
            rt.f3       = 3'($urandom);
            rt.addr     = $urandom;
            rt.wdata    = $urandom;
            rt.rd       = 5'($urandom);
            rt.rdata    = $urandom;
            rt.waits    = $urandom_range(0, 3);
            rt = model(rt);
            run_txn(rt, $sformatf("rnd%0d", i));
        end

        // Never-acked access
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        begin
            int nreq = 0;
            int k;
            for (k = 0; k < 100; k++) begin
                if (!mem_req) break;
                nreq++;
                @(negedge clk);
            end
            check("timeout.nreq", 32'(nreq), 32'(TbTimeout));
            check("timeout.err", 32'(err), 32'd1);
            check("timeout.err_code", 32'(err_code), 32'd3);
            check("timeout.mem_req", 32'(mem_req), 32'd0);
            check("timeout.wb_valid", 32'(wb_valid), 32'd0);
        end
`else
        begin
            int nreq = 0;
            for (int k = 0; k < 1000; k++) begin
                if (mem_req) nreq++;
                @(negedge clk);
            end
            check("noto.nreq", 32'(nreq), 32'd1000);
            check("noto.mem_req", 32'(mem_req), 32'd1);
            check("noto.err", 32'(err), 32'd0);
            mem_ack = 1'b1;
            mem_rdata = 32'h7777_0001;
            @(posedge clk);
            #1 mem_ack = 1'b0;
            @(negedge clk);
            check("noto.wb_valid", 32'(wb_valid), 32'd1);
            check("noto.wb_data", wb_data, 32'h7777_0001);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute-stage ALU. Takes the ALU sum (base + offset) as an effective address and performs RV32I loads and stores against a single-ported data memory that may insert wait states.
- Generates byte enables and lane-aligned store data; sign- or zero-extends load data.
- Back-pressures the execute stage while an access is outstanding, then hands the result to writeback.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack before aborting. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept; a transfer occurs when req_valid & req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  effective address (ALU X output)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  memory request strobe
- mem_we  out  1  write enable
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse: load data or completion
- wb_rd  out  5  destination register (0 for stores)
- wb_data  out  32  extended load data (0 for stores)
- err  out  1  one-cycle pulse: access rejected
- err_code  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout

Behaviour:
- Reset: all outputs 0 except req_ready = 1. FSM returns to IDLE and discards any in-flight access; a late mem_ack after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready = 1.
  - On transfer, latch addr, funct3, rd, wdata, is_store.
  - Decode the access:
    - Illegal: loads with funct3 011/110/111; stores with funct3 other than 000/001/010.
    - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Illegal or misaligned → DONE with error; mem_req is never asserted. Otherwise → ACCESS.
- ACCESS:
  - mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata stay stable until the ack cycle inclusive.
  - req_ready = 0.
  - mem_ack → capture mem_rdata → DONE.
  - mem_ack sampled in IDLE or DONE is ignored.
- DONE:
  - Exactly one cycle.
  - Success: wb_valid = 1. Error: err = 1 with err_code and wb_valid = 0.
  - req_ready = 0 → IDLE.
- Throughput: at most one access per 3 cycles. A zero-wait memory (ack in the first ACCESS cycle) gives accept edge T, mem_req during T+1, wb_valid during T+2.
- Byte enables (addr[1:0] = o):
  - Byte: be = 1 << o.
  - Half: be = 0011 when o = 0, 1100 when o = 2.
  - Word: be = 1111.
- Store data: mem_wdata = replicated rs2 byte/half/word, so every enabled lane carries the correct value.
- Load data: select lane by o, then extend:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Stores produce wb_valid with wb_rd = 0 and wb_data = 0. Regfile writes to x0 are discarded downstream.
- Loads with rd = 0 still perform the memory access.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - After TIMEOUT_CYCLES such cycles, drop mem_req and go to DONE with err_code = 11.
  - The counter saturates and is cleared by reset.
- Undefined: no counter; ACCESS waits indefinitely and err_code 11 is never produced.

Test Plan:
- LB from addr 0x103, mem_rdata 0x80FF_1234, ack after 2 wait cycles → mem_addr 0x100, mem_be 1000, wb_data 0xFFFF_FF80, wb_rd as issued, req_ready low for 4 cycles.
- SH to 0x202, rs2 0x1234_ABCD, zero-wait → mem_we 1, mem_be 1100, mem_wdata 0xABCD_ABCD, wb_valid with wb_rd 0, three cycles total.
- LW from 0x006 → no mem_req, err pulse with err_code 01 one cycle after accept; LHU from 0x006 with rdata 0xBEEF_0000 → wb_data 0x0000_BEEF.
- Load funct3 = 110 → err_code 10, no memory access. Spurious mem_ack while IDLE → no wb_valid.
- rst_n asserted while in ACCESS → mem_req drops immediately, req_ready = 1, a following mem_ack is ignored, and the next LW succeeds.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, never ack → err_code 11 after 4 ACCESS cycles and mem_req deasserted. Without the macro, mem_req is still asserted after 1000 cycles.
